// File: rtl/rs_issue_sched_pkg.sv
// Shared types for the reservation-station issue scheduler: FU class, ROB/PRF
// index widths and the per-entry control record.
`ifndef ROB_IDX_W
`define ROB_IDX_W 5
`endif
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif

package rs_issue_sched_pkg;

  typedef enum logic {
    FU_ALU  = 1'b0,
    FU_MULT = 1'b1
  } fu_t;

  // Age is a ROB distance including the wrap bit.
  localparam int AGE_W = `ROB_IDX_W + 1;

  typedef struct packed {
    logic                  valid;
    fu_t                   fu;
    logic [`ROB_IDX_W:0]   rob_idx;
    logic [`PRF_IDX_W-1:0] src1_tag;
    logic [`PRF_IDX_W-1:0] src2_tag;
    logic                  src1_rdy;
    logic                  src2_rdy;
  } rs_ctrl_ent_t;

endpackage

// File: rtl/rs_issue_sched_if.sv
// Dispatch, CDB and issue signals of the RS scheduler, bundled as one interface.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid
// may drop or its idx change without a transfer, ready never depends on valid.
interface rs_issue_sched_if #(
  parameter int NUM_ENT = 8
);
  localparam int IDX_W = $clog2(NUM_ENT);

  logic                        flush;
  logic [`ROB_IDX_W:0]         rob_head;
  logic                        disp_en;
  rs_issue_sched_pkg::fu_t     disp_fu;
  logic [`ROB_IDX_W:0]         disp_rob_idx;
  logic [`PRF_IDX_W-1:0]       disp_src1_tag;
  logic [`PRF_IDX_W-1:0]       disp_src2_tag;
  logic                        disp_src1_rdy;
  logic                        disp_src2_rdy;
  logic [IDX_W-1:0]            disp_idx;
  logic                        rs_full;
  logic                        cdb_valid;
  logic [`PRF_IDX_W-1:0]       cdb_tag;
  logic                        alu_valid;
  logic                        alu_ready;
  logic [IDX_W-1:0]            alu_idx;
  logic                        mult_valid;
  logic                        mult_ready;
  logic [IDX_W-1:0]            mult_idx;

  modport master (
    output flush, rob_head, disp_en, disp_fu, disp_rob_idx,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           cdb_valid, cdb_tag, alu_ready, mult_ready,
    input  disp_idx, rs_full, alu_valid, alu_idx, mult_valid, mult_idx
  );

  modport slave (
    input  flush, rob_head, disp_en, disp_fu, disp_rob_idx,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           cdb_valid, cdb_tag, alu_ready, mult_ready,
    output disp_idx, rs_full, alu_valid, alu_idx, mult_valid, mult_idx
  );

endinterface

// File: rtl/rs_issue_sched_oldest_finder.sv
// Oldest-requester picker: one-hot grant to the requester with the smallest
// order value; on equal order the lower index wins.
module oldest_finder #(
  parameter int NUM_ENT = 8,
  parameter int AGE_W   = 6
) (
  input  logic                            en,
  input  logic [NUM_ENT-1:0]              req,
  input  logic [NUM_ENT-1:0][AGE_W-1:0]   order,
  output logic [NUM_ENT-1:0]              gnt,
  output logic                            req_up
);
  localparam int IDX_W = $clog2(NUM_ENT);

  logic             found;
  logic [AGE_W-1:0] best_age;
  logic [IDX_W-1:0] best_idx;

  always_comb begin
    found    = 1'b0;
    best_age = '0;
    best_idx = '0;
    gnt      = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (en && req[i] && (!found || order[i] < best_age)) begin
        found    = 1'b1;
        best_age = order[i];
        best_idx = IDX_W'(i);
      end
    end
    gnt[best_idx] = found;
  end

  assign req_up = en && (|req);

endmodule

// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: tracks entry valid/ready/FU state, wakes
// sources from the CDB and issues the oldest ready entry per FU class.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int NUM_ENT  = 8,
  parameter int MULT_LAT = 4
) (
  input logic            clk,
  input logic            rst_n,
  rs_issue_sched_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_ENT);
  localparam int BUSY_W = $clog2(MULT_LAT + 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULT_LAT - 1);

  rs_ctrl_ent_t                  ent_q [NUM_ENT];
  rs_ctrl_ent_t                  ent_d [NUM_ENT];
  logic [BUSY_W-1:0]             mult_busy_q, mult_busy_d;
  logic [NUM_ENT-1:0]            alu_req, mult_req, alu_gnt, mult_gnt;
  logic [NUM_ENT-1:0][AGE_W-1:0] age;
  logic                          alu_any, mult_any, alu_fire, mult_fire;
  logic                          disp_acc, full;
  logic [IDX_W-1:0]              free_idx, alu_enc, mult_enc;

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      age[i]      = ent_q[i].rob_idx - bus.rob_head;
      alu_req[i]  = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy &&
                    (ent_q[i].fu == FU_ALU);
      mult_req[i] = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy &&
                    (ent_q[i].fu == FU_MULT) && (mult_busy_q == '0);
    end
  end

  oldest_finder #(.NUM_ENT(NUM_ENT), .AGE_W(AGE_W)) u_alu_pick (
    .en(1'b1), .req(alu_req), .order(age), .gnt(alu_gnt), .req_up(alu_any)
  );

  oldest_finder #(.NUM_ENT(NUM_ENT), .AGE_W(AGE_W)) u_mult_pick (
    .en(1'b1), .req(mult_req), .order(age), .gnt(mult_gnt), .req_up(mult_any)
  );

  always_comb begin
    alu_enc  = '0;
    mult_enc = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (alu_gnt[i])  alu_enc  = alu_enc  | IDX_W'(i);
      if (mult_gnt[i]) mult_enc = mult_enc | IDX_W'(i);
    end
  end

  // Lowest-index free slot; scanning downward leaves the lowest one last.
  always_comb begin
    full     = 1'b1;
    free_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign bus.alu_valid  = alu_any && !bus.flush;
  assign bus.mult_valid = mult_any && !bus.flush;
  assign bus.alu_idx    = alu_enc;
  assign bus.mult_idx   = mult_enc;
  assign bus.disp_idx   = free_idx;
  assign bus.rs_full    = full;

  assign alu_fire  = bus.alu_valid && bus.alu_ready;
  assign mult_fire = bus.mult_valid && bus.mult_ready;
  assign disp_acc  = bus.disp_en && !full && !bus.flush;

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_d[i] = ent_q[i];
      if (bus.cdb_valid && ent_q[i].valid) begin
        if (ent_q[i].src1_tag == bus.cdb_tag) ent_d[i].src1_rdy = 1'b1;
        if (ent_q[i].src2_tag == bus.cdb_tag) ent_d[i].src2_rdy = 1'b1;
      end
      if ((alu_fire && alu_gnt[i]) || (mult_fire && mult_gnt[i])) ent_d[i].valid = 1'b0;
      // A source broadcast in the dispatch cycle is captured as already ready.
      if (disp_acc && (free_idx == IDX_W'(i))) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].fu       = bus.disp_fu;
        ent_d[i].rob_idx  = bus.disp_rob_idx;
        ent_d[i].src1_tag = bus.disp_src1_tag;
        ent_d[i].src2_tag = bus.disp_src2_tag;
        ent_d[i].src1_rdy = bus.disp_src1_rdy ||
                            (bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag));
        ent_d[i].src2_rdy = bus.disp_src2_rdy ||
                            (bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag));
      end
      if (bus.flush) ent_d[i].valid = 1'b0;
    end
  end

  // The multiplier stays occupied across a flush, so the counter ignores it.
  always_comb begin
    mult_busy_d = mult_busy_q;
    if (mult_fire)               mult_busy_d = BUSY_LOAD;
    else if (mult_busy_q != '0)  mult_busy_d = mult_busy_q - BUSY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= '0;
      mult_busy_q <= '0;
    end else begin
      ent_q       <= ent_d;
      mult_busy_q <= mult_busy_d;
    end
  end

endmodule
